// File: rtl/seg7_mux_scan_pkg.sv
// rtl/seg7_mux_scan_pkg.sv - shared segment type and hex glyph table for the 7-segment scanner
package seg7_pkg;

  typedef logic [6:0] seg_t;  // gfedcba, a = bit 0, active-high

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_mux_scan.sv
// rtl/seg7_mux_scan.sv - N-digit multiplexed 7-segment driver with double buffering and PWM dimming
module seg7_mux_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIV        = 256,
  parameter int PWM_BITS   = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [6:0]            segment,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int              CW      = $clog2(DIV);
  localparam int              IW      = $clog2(DIGITS);
  localparam int              STEP    = DIV >> PWM_BITS;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0]   IDX_MAX = IW'(DIGITS - 1);
  localparam logic            POL     = ACTIVE_LOW;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_value, act_value;
  logic [DIGITS-1:0]     pend_dp, act_dp;
  logic [DIGITS-1:0]     pend_blank, act_blank;
  logic                  pend_lz, act_lz;
  logic                  boundary;

  assign boundary = (cnt == CNT_MAX) && (idx == IDX_MAX);

  // The active buffer only changes at the frame boundary so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      pend_lz    <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      act_lz     <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      if (cnt == CNT_MAX)
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank;
        pend_lz    <= lz_en;
      end
      if (boundary) begin
        act_value <= load ? value : pend_value;
        act_dp    <= load ? dp    : pend_dp;
        act_blank <= load ? blank : pend_blank;
        act_lz    <= load ? lz_en : pend_lz;
      end
    end
  end

  logic [DIGITS-1:0]  sup;
  logic               run;
  logic [3:0]         nib;
  seg_t               dec_seg;
  logic               dig_blank, dig_sup, dig_dp, dark;
  logic [CW:0]        win;
  seg_t               seg_n;
  logic               dp_n;
  logic [DIGITS-1:0]  en_n;

  seg7_hex_decode u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_comb begin
    sup = '0;
    run = 1'b1;
    // Walk from the most significant digit; suppression stops at the first nonzero nibble.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run    = run & (act_value[4*i +: 4] == 4'h0);
      sup[i] = act_lz & run;
    end

    nib       = act_value[{idx, 2'b00} +: 4];
    dig_blank = act_blank[idx];
    dig_sup   = sup[idx];
    dig_dp    = act_dp[idx];
    dark      = dig_blank | (dig_sup & ~dig_dp);

    seg_n = (dig_blank | dig_sup) ? SEG_BLANK : dec_seg;
    dp_n  = ~dark & dig_dp;

    // The last cycle of every slot stays off so the next digit never ghosts the previous one.
    win  = (CW + 1)'((int'(brightness) + 1) * STEP);
    en_n = '0;
    if (!dark && ({1'b0, cnt} < win) && (cnt != CNT_MAX))
      en_n[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segment    <= {7{POL}};
      dp_out     <= POL;
      digit_en   <= {DIGITS{POL}};
      frame_done <= 1'b0;
    end else begin
      segment    <= seg_n ^ {7{POL}};
      dp_out     <= dp_n ^ POL;
      digit_en   <= en_n ^ {DIGITS{POL}};
      frame_done <= boundary;
    end
  end

endmodule

// File: doc/seg7_mux_scan.md
# seg7_mux_scan

Parametrised time-multiplexed N-digit 7-segment display driver with hex decoding, per-digit decimal point and blanking, leading-zero suppression, PWM brightness and tear-free double-buffered updates. Sits between status/debug logic and board display pins, scanning one digit per slot with a one-hot digit enable. Generalises the fixed two-digit raw-segment multiplexer.

## Interface

- DIGITS, 4: number of digits scanned (2..8).
- DIV, 256: clk cycles per digit slot; multiple of 2**PWM_BITS, ≥ 2**PWM_BITS.
- PWM_BITS, 3: brightness resolution.
- ACTIVE_LOW, 0: 1 inverts segment, dp_out and digit_en at the pins.

Reset rst, synchronous, active-high; clock clk.

- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
- dp  in  DIGITS  decimal point per digit.
- blank  in  DIGITS  force digit i dark.
- lz_en  in  1  leading-zero suppression enable.
- load  in  1  capture value/dp/blank/lz_en into pending buffer.
- brightness  in  PWM_BITS  on-time level, sampled every cycle.
- segment  out  7  gfedcba, a = bit 0.
- dp_out  out  1  decimal point of active digit.
- digit_en  out  DIGITS  one-hot (or all-off) digit enable.
- frame_done  out  1  one-cycle pulse at end of each full scan.

## Operation

- Prescaler cnt 0..DIV-1, width $clog2(DIV); digit index idx 0..DIGITS-1 advances when cnt==DIV-1, wraps DIGITS-1→0.
- Two buffers: pending (written on load) and active (drives display). Active ← pending when cnt==DIV-1 and idx==DIGITS-1 (frame boundary). load on the boundary cycle: the newly presented inputs go straight to active.
- Decode (polarity before ACTIVE_LOW): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero suppression (active lz_en=1): digits DIGITS-1 downward with nibble 0 are dark until first nonzero nibble; digit 0 never suppressed. Suppressed digit still shows its dp if set (segments off, digit_en on only if dp set).
- Dark digit (blank or suppressed without dp): segment=0, dp_out=0, digit_en all off for the slot.
- PWM: on-window W = (brightness+1)*(DIV>>PWM_BITS). digit_en[idx] asserted for cnt < W, except always off at cnt==DIV-1 (one-cycle anti-ghost dead time). brightness max → on for DIV-1 cycles.
- segment/dp_out hold the slot's decoded value for the whole slot, including off cycles.
- frame_done=1 for exactly the cycle after the boundary cycle.

## Timing

- All outputs registered; output at cycle t+1 reflects cnt/idx/active at cycle t.
- Reset: cnt=0, idx=0, pending and active cleared with blank all 1s, segment=0, dp_out=0, digit_en=0, frame_done=0 (pin-level inverted if ACTIVE_LOW). load/brightness ignored while rst=1.
- Reset mid-frame: next cycle is reset state; scan restarts at digit 0; previously loaded data lost.
- First frame after reset is dark unless load occurs before its boundary (then second frame shows data).
- Frame period DIGITS*DIV cycles; load-to-visible latency ≤ DIGITS*DIV+1 cycles.
- brightness change mid-slot takes effect next cycle.

## Structure

- Package seg7_pkg: seg_t (logic [6:0]), HEX_SEG[16] constant table, blank constant.
- Sub-module seg7_hex_decode: combinational nibble→seg_t; one instance muxed by idx.
- Top: prescaler, idx counter, pending/active buffers, suppression mask, PWM compare, output registers, polarity inversion.

## Test plan

- DIGITS=4, DIV=16, PWM_BITS=2: load value=16'h12AF, dp=0, brightness=3 → per frame digit_en 0001,0010,0100,1000, segments 71,77,5B,06; each enable on 15 of 16 cycles; frame_done every 64 cycles.
- lz_en=1, value=16'h0040 → digits 3,2 dark (digit_en 0 in their slots), digit 1=66, digit 0=3F; value=0 → only digit 0 lit with 3F.
- brightness=0 → digit_en high 4 cycles per 16-cycle slot; brightness=1 → 8 cycles.
- load 16'h1111 mid-frame then 16'h2222 on boundary cycle → next frame shows 2222; no frame mixes 1 and 2 patterns.
- rst asserted mid-slot at idx=2 → next cycle all outputs zero, idx=0, display dark until load + boundary.
- ACTIVE_LOW=1, blank=4'b0100 → all pins inverted; digit 2 pins stay high (inactive) through its slot.
